// File: rtl/vga_timing_gen_param_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_param_if
//
// Bundles the video-side signals of vga_timing_gen_param so the generator,
// the frame-buffer read logic and the DAC/encoder wrapper can share a
// single connection.
//
//   master : the timing generator. Takes the pattern select and buffer
//            pixel in; drives request, syncs, DE, colour, coordinates and
//            the per-line / per-frame strobes.
//   slave  : the consumer side (buffer read logic and pin driver). Drives
//            pattern select and buffer pixel; sees everything else.
//
// Parameters must match the generator instance:
//   CW  bits per colour channel
//   HCW horizontal coordinate width
//   VCW vertical coordinate width
// ---------------------------------------------------------------------------
interface vga_timing_gen_param_if #(
   parameter int CW  = 8,
   parameter int HCW = 12,
   parameter int VCW = 11
);

   logic [1:0]      VGA_MODE;
   logic [3*CW-1:0] VGA_BUF_RGB;
   logic            VGA_REQ;
   logic            VGA_HSYNC;
   logic            VGA_VSYNC;
   logic            VGA_DE;
   logic [CW-1:0]   VGA_R;
   logic [CW-1:0]   VGA_G;
   logic [CW-1:0]   VGA_B;
   logic [HCW-1:0]  VGA_X;
   logic [VCW-1:0]  VGA_Y;
   logic            VGA_LINE_START;
   logic            VGA_FRAME_START;
   logic            VGA_SYNC_N;
   logic            VGA_BLANK_N;

   modport master (
      input  VGA_MODE,
      input  VGA_BUF_RGB,
      output VGA_REQ,
      output VGA_HSYNC,
      output VGA_VSYNC,
      output VGA_DE,
      output VGA_R,
      output VGA_G,
      output VGA_B,
      output VGA_X,
      output VGA_Y,
      output VGA_LINE_START,
      output VGA_FRAME_START,
      output VGA_SYNC_N,
      output VGA_BLANK_N
   );

   modport slave (
      output VGA_MODE,
      output VGA_BUF_RGB,
      input  VGA_REQ,
      input  VGA_HSYNC,
      input  VGA_VSYNC,
      input  VGA_DE,
      input  VGA_R,
      input  VGA_G,
      input  VGA_B,
      input  VGA_X,
      input  VGA_Y,
      input  VGA_LINE_START,
      input  VGA_FRAME_START,
      input  VGA_SYNC_N,
      input  VGA_BLANK_N
   );

endinterface

// File: rtl/vga_timing_gen_param.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_param
//
// Single-clock VGA/DVI raster timing generator. A horizontal counter h and
// a vertical counter v advance on the same VGA_CLK edge; every output is a
// register loaded from the decode of the previous cycle's counter state,
// so the whole output bundle has exactly one cycle of latency and stays
// mutually aligned.
//
// Ports
//   VGA_CLK          pixel clock
//   VGA_RST          asynchronous reset, active-high; forces every output
//                    to its idle value immediately
//   vga (master)     video bundle, see vga_timing_gen_param_if:
//     VGA_MODE        pattern select, sampled once per frame at h=0,v=0
//                     (0 buffer, 1 colour bars, 2 checker, 3 grey ramp)
//     VGA_BUF_RGB     buffer pixel {R,G,B}, valid LEAD-1 cycles after REQ
//     VGA_REQ         pixel fetch request, LEAD cycles ahead of DE
//     VGA_HSYNC/VSYNC sync outputs, active level H_POL / V_POL
//     VGA_DE          active video (VGA_BLANK_N mirrors it)
//     VGA_R/G/B       colour, 0 outside the active region
//     VGA_X/Y         active pixel coordinates, 0 outside the active region
//     VGA_LINE_START  one-cycle pulse with the output of h=0
//     VGA_FRAME_START one-cycle pulse with the output of h=0,v=0
//     VGA_SYNC_N      tied low
//
// Parameter constraints: H_ACT multiple of 8, 4 <= CW <= 10, HCW >= CW,
// VCW >= 4, 1 <= LEAD <= H_BP, HCW/VCW wide enough for H_TOTAL-1/V_TOTAL-1.
// ---------------------------------------------------------------------------
module vga_timing_gen_param #(
   parameter int H_SYNC = 136,
   parameter int H_BP   = 160,
   parameter int H_ACT  = 1024,
   parameter int H_FP   = 24,
   parameter int V_SYNC = 6,
   parameter int V_BP   = 29,
   parameter int V_ACT  = 768,
   parameter int V_FP   = 3,
   parameter int H_POL  = 0,
   parameter int V_POL  = 0,
   parameter int CW     = 8,
   parameter int LEAD   = 2,
   parameter int HCW    = 12,
   parameter int VCW    = 11
) (
   input  logic                   VGA_CLK,
   input  logic                   VGA_RST,
   vga_timing_gen_param_if.master vga
);

   typedef logic [HCW-1:0]  h_t;
   typedef logic [HCW:0]    hw_t;
   typedef logic [VCW-1:0]  v_t;
   typedef logic [3*CW-1:0] rgb_t;

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
   localparam int HA0     = H_SYNC + H_BP;
   localparam int VA0     = V_SYNC + V_BP;

   localparam h_t  H_LAST   = h_t'(H_TOTAL - 1);
   localparam h_t  H_SYNC_E = h_t'(H_SYNC);
   localparam h_t  HA0_E    = h_t'(HA0);
   localparam h_t  HA1_E    = h_t'(HA0 + H_ACT);
   localparam h_t  BAR_W    = h_t'(H_ACT / 8);

   // One bit wider than h so h+LEAD never wraps back into the line start.
   localparam hw_t HA0_W    = hw_t'(HA0);
   localparam hw_t HA1_W    = hw_t'(HA0 + H_ACT);
   localparam hw_t LEAD_W   = hw_t'(LEAD);

   localparam v_t  V_LAST   = v_t'(V_TOTAL - 1);
   localparam v_t  V_SYNC_E = v_t'(V_SYNC);
   localparam v_t  VA0_E    = v_t'(VA0);
   localparam v_t  VA1_E    = v_t'(VA0 + V_ACT);

   localparam logic HS_ON   = (H_POL != 0);
   localparam logic VS_ON   = (V_POL != 0);

   localparam logic [1:0] MODE_BUF   = 2'd0;
   localparam logic [1:0] MODE_BARS  = 2'd1;
   localparam logic [1:0] MODE_CHECK = 2'd2;
   localparam logic [1:0] MODE_GREY  = 2'd3;

   // Bar order white, yellow, cyan, green, magenta, red, blue, black:
   // R is lit for bars 0,1,4,5, G for 0..3, B for the even bars.
   function automatic rgb_t bar_rgb(input h_t x);
      logic [2:0] idx;
      idx = 3'(x / BAR_W);
      return {{CW{~idx[1]}}, {CW{~idx[2]}}, {CW{~idx[0]}}};
   endfunction

   function automatic rgb_t checker_rgb(input logic xb, input logic yb);
      return (xb ^ yb) ? {(3*CW){1'b1}} : '0;
   endfunction

   function automatic rgb_t grey_rgb(input logic [CW-1:0] g);
      return {g, g, g};
   endfunction

   h_t         h_p0;
   v_t         v_p0;
   logic [1:0] mode_p0;
   logic       frame_top_p0;
   logic       h_act_p0;
   logic       v_act_p0;
   logic       vld_p0;
   logic       req_p0;
   hw_t        h_lead_p0;
   h_t         x_p0;
   v_t         y_p0;
   rgb_t       rgb_p0;

   logic       hsync_p1;
   logic       vsync_p1;
   logic       vld_p1;
   logic       req_p1;
   rgb_t       rgb_p1;
   h_t         x_p1;
   v_t         y_p1;
   logic       line_p1;
   logic       frame_p1;

   // ---- stage p0: raster counters and per-frame mode latch ----
   always_ff @(posedge VGA_CLK or posedge VGA_RST) begin
      if (VGA_RST) begin
         h_p0 <= '0;
         v_p0 <= '0;
      end else if (h_p0 == H_LAST) begin
         h_p0 <= '0;
         if (v_p0 == V_LAST) begin
            v_p0 <= '0;
         end else begin
            v_p0 <= v_p0 + 1'b1;
         end
      end else begin
         h_p0 <= h_p0 + 1'b1;
      end
   end

   assign frame_top_p0 = (h_p0 == '0) && (v_p0 == '0);

   // The pattern select only moves at the top of the frame so a frame is
   // never split between two patterns.
   always_ff @(posedge VGA_CLK or posedge VGA_RST) begin
      if (VGA_RST) begin
         mode_p0 <= MODE_BUF;
      end else if (frame_top_p0) begin
         mode_p0 <= vga.VGA_MODE;
      end
   end

   assign h_act_p0  = (h_p0 >= HA0_E) && (h_p0 < HA1_E);
   assign v_act_p0  = (v_p0 >= VA0_E) && (v_p0 < VA1_E);
   assign vld_p0    = h_act_p0 && v_act_p0;

   // Request window is the active window shifted LEAD pixels earlier; it
   // never reaches past the end of the current line.
   assign h_lead_p0 = {1'b0, h_p0} + LEAD_W;
   assign req_p0    = (mode_p0 == MODE_BUF) && v_act_p0 &&
                      (h_lead_p0 >= HA0_W) && (h_lead_p0 < HA1_W);

   always_comb begin
      x_p0   = '0;
      y_p0   = '0;
      rgb_p0 = '0;
      if (vld_p0) begin
         x_p0 = h_p0 - HA0_E;
         y_p0 = v_p0 - VA0_E;
         case (mode_p0)
            MODE_BUF:   rgb_p0 = vga.VGA_BUF_RGB;
            MODE_BARS:  rgb_p0 = bar_rgb(x_p0);
            MODE_CHECK: rgb_p0 = checker_rgb(x_p0[3], y_p0[3]);
            default:    rgb_p0 = grey_rgb(x_p0[CW-1:0]);
         endcase
      end
   end

   // ---- stage p1: registered outputs ----
   always_ff @(posedge VGA_CLK or posedge VGA_RST) begin
      if (VGA_RST) begin
         hsync_p1 <= ~HS_ON;
         vsync_p1 <= ~VS_ON;
         vld_p1   <= 1'b0;
         req_p1   <= 1'b0;
         rgb_p1   <= '0;
         x_p1     <= '0;
         y_p1     <= '0;
         line_p1  <= 1'b0;
         frame_p1 <= 1'b0;
      end else begin
         hsync_p1 <= (h_p0 < H_SYNC_E) ? HS_ON : ~HS_ON;
         vsync_p1 <= (v_p0 < V_SYNC_E) ? VS_ON : ~VS_ON;
         vld_p1   <= vld_p0;
         req_p1   <= req_p0;
         rgb_p1   <= rgb_p0;
         x_p1     <= x_p0;
         y_p1     <= y_p0;
         line_p1  <= (h_p0 == '0);
         frame_p1 <= frame_top_p0;
      end
   end

   assign vga.VGA_HSYNC       = hsync_p1;
   assign vga.VGA_VSYNC       = vsync_p1;
   assign vga.VGA_DE          = vld_p1;
   assign vga.VGA_BLANK_N     = vld_p1;
   assign vga.VGA_REQ         = req_p1;
   assign vga.VGA_R           = rgb_p1[3*CW-1:2*CW];
   assign vga.VGA_G           = rgb_p1[2*CW-1:CW];
   assign vga.VGA_B           = rgb_p1[CW-1:0];
   assign vga.VGA_X           = x_p1;
   assign vga.VGA_Y           = y_p1;
   assign vga.VGA_LINE_START  = line_p1;
   assign vga.VGA_FRAME_START = frame_p1;
   assign vga.VGA_SYNC_N      = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen_param
//
// Three generator instances share one clock and reset:
//   dut_b  default horizontal timing (1344 clocks/line), short vertical
//          timing 6/2/4/2 (14 lines/frame); pattern select driven by the
//          bench across frames (bars, buffer, checker)
//   dut_c  small timing H 4/4/8/4, V 2/2/4/2, LEAD 3, CW 4, buffer mode
//   dut_d  same small timing, LEAD 1, active-high syncs, grey ramp
// Cycle k counts negedges after reset release; its outputs reflect the
// counter state s = k-1 (h = s mod H_TOTAL, v = s div H_TOTAL mod V_TOTAL).
// Buffer inputs carry a counter that steps once per clock.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen_param;

   logic        clk;
   logic        rst;
   logic [23:0] cnt;
   int          cyc;
   int          checks;
   int          failures;
   int          acc_hs, acc_vs, acc_de, acc_req, acc_ls, acc_fs;

   vga_timing_gen_param_if #(.CW(8), .HCW(12), .VCW(11)) ifb ();
   vga_timing_gen_param_if #(.CW(4), .HCW(5),  .VCW(4))  ifc ();
   vga_timing_gen_param_if #(.CW(4), .HCW(5),  .VCW(4))  ifd ();

   vga_timing_gen_param #(
      .V_SYNC(6), .V_BP(2), .V_ACT(4), .V_FP(2)
   ) dut_b (
      .VGA_CLK(clk), .VGA_RST(rst), .vga(ifb)
   );

   vga_timing_gen_param #(
      .H_SYNC(4), .H_BP(4), .H_ACT(8), .H_FP(4),
      .V_SYNC(2), .V_BP(2), .V_ACT(4), .V_FP(2),
      .LEAD(3), .CW(4), .HCW(5), .VCW(4)
   ) dut_c (
      .VGA_CLK(clk), .VGA_RST(rst), .vga(ifc)
   );

   vga_timing_gen_param #(
      .H_SYNC(4), .H_BP(4), .H_ACT(8), .H_FP(4),
      .V_SYNC(2), .V_BP(2), .V_ACT(4), .V_FP(2),
      .H_POL(1), .V_POL(1),
      .LEAD(1), .CW(4), .HCW(5), .VCW(4)
   ) dut_d (
      .VGA_CLK(clk), .VGA_RST(rst), .vga(ifd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Buffer data: steps 2 time units after each rising edge.
   initial begin
      cnt = 24'd0;
      ifb.VGA_BUF_RGB = cnt;
      ifc.VGA_BUF_RGB = cnt[11:0];
      ifd.VGA_BUF_RGB = cnt[11:0];
      forever begin
         @(posedge clk);
         #2;
         cnt = cnt + 24'd1;
         ifb.VGA_BUF_RGB = cnt;
         ifc.VGA_BUF_RGB = cnt[11:0];
         ifd.VGA_BUF_RGB = cnt[11:0];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic zero_acc();
      acc_hs = 0; acc_vs = 0; acc_de = 0; acc_req = 0; acc_ls = 0; acc_fs = 0;
   endtask

   task automatic adv(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc++;
         if (!ifb.VGA_HSYNC)      acc_hs++;
         if (!ifb.VGA_VSYNC)      acc_vs++;
         if (ifb.VGA_DE)          acc_de++;
         if (ifb.VGA_REQ)         acc_req++;
         if (ifb.VGA_LINE_START)  acc_ls++;
         if (ifb.VGA_FRAME_START) acc_fs++;
      end
   endtask

   task automatic goto_cyc(input int t);
      adv(t - cyc);
   endtask

   initial begin
      int          reqc, dec, reqd, first_req, last_req, first_de, last_de;
      logic [23:0] prev;
      logic [3:0]  g;

      checks = 0;
      failures = 0;
      cyc = 0;
      zero_acc();
      rst = 1'b1;
      ifb.VGA_MODE = 2'd1;
      ifc.VGA_MODE = 2'd0;
      ifd.VGA_MODE = 2'd3;
      repeat (3) @(negedge clk);

      // reset values
      chk("rst_hsync_b", 32'(ifb.VGA_HSYNC), 32'd1);
      chk("rst_vsync_b", 32'(ifb.VGA_VSYNC), 32'd1);
      chk("rst_de_b", 32'(ifb.VGA_DE), 32'd0);
      chk("rst_req_b", 32'(ifb.VGA_REQ), 32'd0);
      chk("rst_rgb_b", 32'({ifb.VGA_R, ifb.VGA_G, ifb.VGA_B}), 32'd0);
      chk("rst_x_b", 32'(ifb.VGA_X), 32'd0);
      chk("rst_y_b", 32'(ifb.VGA_Y), 32'd0);
      chk("rst_ls_b", 32'(ifb.VGA_LINE_START), 32'd0);
      chk("rst_fs_b", 32'(ifb.VGA_FRAME_START), 32'd0);
      chk("rst_blank_n_b", 32'(ifb.VGA_BLANK_N), 32'd0);
      chk("sync_n_b", 32'(ifb.VGA_SYNC_N), 32'd0);
      chk("rst_hsync_d", 32'(ifd.VGA_HSYNC), 32'd0);
      chk("rst_vsync_d", 32'(ifd.VGA_VSYNC), 32'd0);

      rst = 1'b0;
      cyc = 0;
      zero_acc();

      // first edge: h=0, v=0
      adv(1);
      chk("c1_fs_b", 32'(ifb.VGA_FRAME_START), 32'd1);
      chk("c1_ls_b", 32'(ifb.VGA_LINE_START), 32'd1);
      chk("c1_hsync_b", 32'(ifb.VGA_HSYNC), 32'd0);
      chk("c1_vsync_b", 32'(ifb.VGA_VSYNC), 32'd0);
      chk("c1_de_b", 32'(ifb.VGA_DE), 32'd0);
      chk("c1_fs_c", 32'(ifc.VGA_FRAME_START), 32'd1);
      chk("c1_hsync_d", 32'(ifd.VGA_HSYNC), 32'd1);
      chk("c1_vsync_d", 32'(ifd.VGA_VSYNC), 32'd1);
      adv(1);
      chk("c2_fs_b", 32'(ifb.VGA_FRAME_START), 32'd0);
      chk("c2_ls_b", 32'(ifb.VGA_LINE_START), 32'd0);

      // small configs: hsync 4 clocks, vsync 2 lines
      goto_cyc(4);
      chk("c4_hsync_d", 32'(ifd.VGA_HSYNC), 32'd1);
      chk("c4_hsync_c", 32'(ifc.VGA_HSYNC), 32'd0);
      goto_cyc(5);
      chk("c5_hsync_d", 32'(ifd.VGA_HSYNC), 32'd0);
      chk("c5_hsync_c", 32'(ifc.VGA_HSYNC), 32'd1);
      goto_cyc(40);
      chk("c40_vsync_c", 32'(ifc.VGA_VSYNC), 32'd0);
      chk("c40_vsync_d", 32'(ifd.VGA_VSYNC), 32'd1);
      goto_cyc(41);
      chk("c41_vsync_c", 32'(ifc.VGA_VSYNC), 32'd1);
      chk("c41_vsync_d", 32'(ifd.VGA_VSYNC), 32'd0);

      // small configs, first active line (cycles 81..100): DE 89..96
      goto_cyc(80);
      reqc = 0; dec = 0; reqd = 0;
      first_req = 0; last_req = 0; first_de = 0; last_de = 0;
      for (int i = 0; i < 20; i++) begin
         adv(1);
         if (ifc.VGA_REQ) begin
            reqc++;
            if (first_req == 0) first_req = cyc;
            last_req = cyc;
         end
         if (ifc.VGA_DE) begin
            dec++;
            if (first_de == 0) first_de = cyc;
            last_de = cyc;
         end
         if (ifd.VGA_REQ) reqd++;
         if (cyc >= 89 && cyc <= 96) begin
            prev = cnt - 24'd1;
            g = 4'(cyc - 89);
            chk("small_x_c", 32'(ifc.VGA_X), 32'(cyc - 89));
            chk("small_rgb_c", 32'({ifc.VGA_R, ifc.VGA_G, ifc.VGA_B}), 32'(prev[11:0]));
            chk("grey_rgb_d", 32'({ifd.VGA_R, ifd.VGA_G, ifd.VGA_B}), 32'({g, g, g}));
         end
      end
      chk("small_req_cnt_c", reqc, 8);
      chk("small_req_first_c", first_req, 86);
      chk("small_req_last_c", last_req, 93);
      chk("small_de_cnt_c", dec, 8);
      chk("small_de_first_c", first_de, 89);
      chk("small_de_last_c", last_de, 96);
      chk("grey_req_cnt_d", reqd, 0);

      // default line: hsync 136 clocks, 1344 clocks per line
      goto_cyc(136);
      chk("c136_hsync_b", 32'(ifb.VGA_HSYNC), 32'd0);
      goto_cyc(137);
      chk("c137_hsync_b", 32'(ifb.VGA_HSYNC), 32'd1);
      goto_cyc(1344);
      chk("line0_hs_low_b", acc_hs, 136);
      chk("line0_ls_cnt_b", acc_ls, 1);
      goto_cyc(1345);
      chk("line1_ls_b", 32'(ifb.VGA_LINE_START), 32'd1);

      // frame 0, colour bars on line 8
      goto_cyc(11048);
      chk("bars_pre_de_b", 32'(ifb.VGA_DE), 32'd0);
      chk("bars_pre_req_b", 32'(ifb.VGA_REQ), 32'd0);
      goto_cyc(11049);
      chk("bars_x0_de_b", 32'(ifb.VGA_DE), 32'd1);
      chk("bars_x0_x_b", 32'(ifb.VGA_X), 32'd0);
      chk("bars_x0_y_b", 32'(ifb.VGA_Y), 32'd0);
      chk("bars_x0_rgb_b", 32'({ifb.VGA_R, ifb.VGA_G, ifb.VGA_B}), 32'h00FFFFFF);
      goto_cyc(11049 + 127);
      chk("bars_x127_rgb_b", 32'({ifb.VGA_R, ifb.VGA_G, ifb.VGA_B}), 32'h00FFFFFF);
      goto_cyc(11049 + 128);
      chk("bars_x128_x_b", 32'(ifb.VGA_X), 32'd128);
      chk("bars_x128_rgb_b", 32'({ifb.VGA_R, ifb.VGA_G, ifb.VGA_B}), 32'h00FFFF00);
      goto_cyc(11049 + 256);
      chk("bars_x256_rgb_b", 32'({ifb.VGA_R, ifb.VGA_G, ifb.VGA_B}), 32'h0000FFFF);
      goto_cyc(11049 + 640);
      chk("bars_x640_rgb_b", 32'({ifb.VGA_R, ifb.VGA_G, ifb.VGA_B}), 32'h00FF0000);
      goto_cyc(11049 + 896);
      chk("bars_x896_rgb_b", 32'({ifb.VGA_R, ifb.VGA_G, ifb.VGA_B}), 32'h00000000);
      chk("bars_x896_de_b", 32'(ifb.VGA_DE), 32'd1);
      goto_cyc(11049 + 1023);
      chk("bars_x1023_x_b", 32'(ifb.VGA_X), 32'd1023);
      chk("bars_x1023_rgb_b", 32'({ifb.VGA_R, ifb.VGA_G, ifb.VGA_B}), 32'h00000000);
      goto_cyc(11049 + 1024);
      chk("bars_end_de_b", 32'(ifb.VGA_DE), 32'd0);
      chk("bars_end_x_b", 32'(ifb.VGA_X), 32'd0);

      // switch to buffer mode mid-frame; frame 0 totals
      goto_cyc(13000);
      ifb.VGA_MODE = 2'd0;
      goto_cyc(18816);
      chk("f0_vs_low_b", acc_vs, 8064);
      chk("f0_hs_low_b", acc_hs, 1904);
      chk("f0_de_cnt_b", acc_de, 4096);
      chk("f0_req_cnt_b", acc_req, 0);
      chk("f0_ls_cnt_b", acc_ls, 14);
      chk("f0_fs_cnt_b", acc_fs, 1);
      zero_acc();
      goto_cyc(18817);
      chk("f1_fs_b", 32'(ifb.VGA_FRAME_START), 32'd1);

      // frame 1, buffer mode: REQ leads DE by 2
      goto_cyc(29862);
      chk("f1_req_pre_b", 32'(ifb.VGA_REQ), 32'd0);
      goto_cyc(29863);
      chk("f1_req_rise_b", 32'(ifb.VGA_REQ), 32'd1);
      chk("f1_req_rise_de_b", 32'(ifb.VGA_DE), 32'd0);
      goto_cyc(29873);
      prev = cnt - 24'd1;
      chk("f1_x8_x_b", 32'(ifb.VGA_X), 32'd8);
      chk("f1_x8_rgb_b", 32'({ifb.VGA_R, ifb.VGA_G, ifb.VGA_B}), 32'(prev));

      // select checker mid-frame; this frame stays buffer data
      goto_cyc(30913);
      ifb.VGA_MODE = 2'd2;
      goto_cyc(32561);
      prev = cnt - 24'd1;
      chk("f1_y2_y_b", 32'(ifb.VGA_Y), 32'd2);
      chk("f1_y2_rgb_b", 32'({ifb.VGA_R, ifb.VGA_G, ifb.VGA_B}), 32'(prev));
      goto_cyc(37632);
      chk("f1_req_cnt_b", acc_req, 4096);
      chk("f1_de_cnt_b", acc_de, 4096);
      zero_acc();
      goto_cyc(37633);
      chk("f2_fs_b", 32'(ifb.VGA_FRAME_START), 32'd1);

      // frame 2, checker
      goto_cyc(48681);
      chk("f2_p00_rgb_b", 32'({ifb.VGA_R, ifb.VGA_G, ifb.VGA_B}), 32'h00000000);
      chk("f2_p00_de_b", 32'(ifb.VGA_DE), 32'd1);
      goto_cyc(48689);
      chk("f2_p80_x_b", 32'(ifb.VGA_X), 32'd8);
      chk("f2_p80_rgb_b", 32'({ifb.VGA_R, ifb.VGA_G, ifb.VGA_B}), 32'h00FFFFFF);
      chk("f2_req_cnt_b", acc_req, 0);

      // reset mid-line at h=500 on active line 10
      goto_cyc(51573);
      chk("pre_rst_de_b", 32'(ifb.VGA_DE), 32'd1);
      chk("pre_rst_x_b", 32'(ifb.VGA_X), 32'd204);
      chk("pre_rst_y_b", 32'(ifb.VGA_Y), 32'd2);
      chk("pre_rst_rgb_b", 32'({ifb.VGA_R, ifb.VGA_G, ifb.VGA_B}), 32'h00FFFFFF);
      rst = 1'b1;
      #1;
      chk("mid_rst_de_b", 32'(ifb.VGA_DE), 32'd0);
      chk("mid_rst_x_b", 32'(ifb.VGA_X), 32'd0);
      chk("mid_rst_y_b", 32'(ifb.VGA_Y), 32'd0);
      chk("mid_rst_rgb_b", 32'({ifb.VGA_R, ifb.VGA_G, ifb.VGA_B}), 32'd0);
      chk("mid_rst_hsync_b", 32'(ifb.VGA_HSYNC), 32'd1);
      chk("mid_rst_vsync_b", 32'(ifb.VGA_VSYNC), 32'd1);
      chk("mid_rst_blank_n_b", 32'(ifb.VGA_BLANK_N), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cyc = 0;
      zero_acc();
      adv(1);
      chk("post_rst_fs_b", 32'(ifb.VGA_FRAME_START), 32'd1);
      chk("post_rst_hsync_b", 32'(ifb.VGA_HSYNC), 32'd0);
      goto_cyc(1344);
      chk("post_rst_ls_cnt_b", acc_ls, 1);
      goto_cyc(1345);
      chk("post_rst_ls_b", 32'(ifb.VGA_LINE_START), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen_param.md
# vga_timing_gen_param

Parametrised single-clock VGA/DVI raster timing generator with configurable sync polarity, channel width, buffer prefetch lead and built-in test-pattern modes. It sits between the frame buffer read logic and the video DAC/encoder pins. It produces registered HSYNC/VSYNC/DE/RGB, pixel coordinates and a lead-adjustable pixel request. Horizontal and vertical counters advance on the same clock edge; no logic is clocked from derived sync signals.

## Interface
- H_SYNC, 136: horizontal sync width, pixels
- H_BP, 160: horizontal back porch
- H_ACT, 1024: active pixels per line; must be a multiple of 8
- H_FP, 24: horizontal front porch
- V_SYNC, 6: vertical sync width, lines
- V_BP, 29: vertical back porch
- V_ACT, 768: active lines
- V_FP, 3: vertical front porch
- H_POL, 0: HSYNC active level (0 = active-low)
- V_POL, 0: VSYNC active level
- CW, 8: bits per colour channel, 4..10
- LEAD, 2: cycles from REQ to matching DE, 1..H_BP
- HCW, 12 / VCW, 11: counter widths; must hold H_TOTAL-1 and V_TOTAL-1
- VGA_CLK  in  1  pixel clock
- VGA_RST  in  1  asynchronous reset, active-high
- VGA_MODE  in  2  pattern select; 0 buffer, 1 colour bars, 2 checker, 3 grey ramp
- VGA_BUF_RGB  in  3*CW  buffer pixel {R,G,B}
- VGA_REQ  out  1  pixel fetch request (buffer mode only)
- VGA_HSYNC / VGA_VSYNC  out  1  sync outputs
- VGA_DE  out  1  active video
- VGA_R / VGA_G / VGA_B  out  CW  colour outputs
- VGA_X  out  HCW  active-pixel column, 0 outside DE
- VGA_Y  out  VCW  active line, 0 outside DE
- VGA_LINE_START / VGA_FRAME_START  out  1  one-cycle pulses
- VGA_SYNC_N  out  1  constant 0
- VGA_BLANK_N  out  1  equals VGA_DE

## Operation
- H_TOTAL = sum of H params; V_TOTAL likewise. HA0 = H_SYNC+H_BP; VA0 = V_SYNC+V_BP.
- h counts 0..H_TOTAL-1 and wraps. v increments when h = H_TOTAL-1 and wraps after V_TOTAL-1.
- Sync is active for h < H_SYNC and for v < V_SYNC (whole lines). Sync-active level = POL.
- Active region: HA0 <= h < HA0+H_ACT and VA0 <= v < VA0+V_ACT. X = h-HA0, Y = v-VA0.
- All outputs are registered from the counter state of the previous cycle.
- Mode latch: VGA_MODE is sampled only when h=0, v=0. A mid-frame change takes effect from the next frame.
- Mode 0, buffer: REQ is asserted when (h+LEAD) falls in the active region on an active line. The REQ count per line equals H_ACT exactly, with no wrap into the next line. RGB = VGA_BUF_RGB sampled in the cycle before DE.
- Mode 1, colour bars: 8 bars of width H_ACT/8, bar index = X/(H_ACT/8). Order: white, yellow, cyan, green, magenta, red, blue, black. Channels are full-scale (all ones) or 0.
- Mode 2, checker: X[3]^Y[3] = 1 gives white, otherwise black.
- Mode 3, grey ramp: R = G = B = X[CW-1:0].
- In modes 1-3, REQ is held at 0.
- Outside the active region: RGB = 0, X = 0, Y = 0.
- LINE_START pulses with the output of h=0 on every line. FRAME_START pulses with the output of h=0, v=0.

## Timing
- Reset values, asynchronous: h = v = 0; HSYNC = ~H_POL; VSYNC = ~V_POL; DE = REQ = 0; RGB = X = Y = 0; pulses 0; latched mode 0.
- First clock edge after reset release: outputs reflect h=0, v=0. HSYNC and VSYNC go active and FRAME_START pulses.
- DE rises 1 cycle after h = HA0. REQ rises exactly LEAD cycles before DE and falls LEAD cycles before DE falls.
- Buffer read latency: data for a REQ asserted in cycle n must be valid on VGA_BUF_RGB in cycle n+LEAD-1. It appears on RGB in cycle n+LEAD, when DE is high.
- VSYNC edges coincide with HSYNC leading edges.
- Reset asserted mid-line forces every output to its reset value within the same cycle, with no wait for a clock edge.
- Pattern and sync outputs have 1-cycle latency. Nothing stalls; there is no back-pressure.

## Test plan
- Defaults, mode 0: count 1344 clocks per line and 806 lines per frame. Check HSYNC low for 136 clocks, VSYNC low for 6 lines, DE high for 1024 clocks on each of 768 lines.
- Small config (H 4/4/8/4, V 2/2/4/2, LEAD 3), mode 0: drive BUF_RGB = free-running counter. Check REQ high for 8 cycles starting 3 cycles before DE. Check RGB equals the counter value from the cycle before, and X runs 0..7.
- H_POL = 1, V_POL = 1: syncs idle low and pulse high; reset values are 0.
- Mode 1, defaults: X = 0..127 gives RGB = FF/FF/FF; X = 128 gives FF/FF/00; X = 896..1023 gives 0/0/0. REQ stays 0 throughout.
- Change VGA_MODE from 0 to 2 at v = 100: the current frame stays buffer data. The next frame shows pixel (8,0) white and pixel (0,0) black.
- Assert reset at h = 500, v = 400: outputs reach reset values immediately. After release, FRAME_START pulses on the first edge and the line length is again 1344.
